jk_cmd_sequencer: RTL
=====================

JK_CMD_SEQUENCER -- requirements
Module: jk_cmd_sequencer

Interface
REQ-001 Parameter DEPTH, default 4, is the command FIFO depth in entries; it SHALL be a power of two and at least 2.
REQ-002 Parameter CNT_W, default 4, is the width of the per-command repeat count.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 cmd_valid  in  1  command offered.
REQ-006 cmd_op  in  2  operation: 00 HOLD, 01 CLR, 10 SET, 11 TOG.
REQ-007 cmd_cnt  in  CNT_W  number of cycles to drive the op; 0 SHALL be treated as 1.
REQ-008 cmd_ready  out  1  command accepted when high together with cmd_valid.
REQ-009 flush  in  1  synchronous abort and FIFO clear.
REQ-010 j  out  1  J drive to the downstream JK flip-flop stage; registered.
REQ-011 k  out  1  K drive to the downstream JK flip-flop stage; registered.
REQ-012 busy  out  1  high while in DRIVE or while the FIFO is non-empty.
REQ-013 cmd_done  out  1  one-cycle pulse during the final drive cycle of each command.

Function
REQ-014 A command SHALL be accepted at a rising edge where cmd_valid and cmd_ready are both high; it SHALL be written to the FIFO tail.
REQ-015 cmd_ready SHALL equal (FIFO not full) AND (not flush); cmd_valid with cmd_ready low SHALL be ignored.
REQ-016 The FSM SHALL have two states: IDLE and DRIVE.
REQ-017 IDLE: j=k=0. If the FIFO is non-empty, the head SHALL be popped, its op latched, remaining set to max(cmd_cnt,1), and the FSM SHALL move to DRIVE.
REQ-018 DRIVE: j/k SHALL follow the latched op (HOLD 0/0, CLR 0/1, SET 1/0, TOG 1/1), and remaining SHALL decrement each cycle.
REQ-019 When remaining==1 in DRIVE, cmd_done SHALL be high. At the next edge the FSM SHALL either pop the next head (no gap cycle) if the FIFO is non-empty, or return to IDLE.
REQ-020 Latency: a command accepted at edge E into an empty, idle block SHALL drive j/k in the cycles following edges E+1 through E+cnt. There is no FIFO bypass.
REQ-021 A push and a pop in the same cycle SHALL both take effect, leaving the occupancy unchanged.
REQ-022 FIFO pointers SHALL wrap modulo DEPTH; full/empty SHALL be distinguished by an extra pointer bit.
REQ-023 flush high at an edge SHALL:
  - empty the FIFO;
  - force IDLE and j=k=0 from the next cycle;
  - suppress cmd_done;
  - drop any same-cycle push.
REQ-024 Internal count arithmetic SHALL be CNT_W bits; a cmd_cnt of all-ones SHALL yield exactly 2^CNT_W-1 drive cycles.

Reset
REQ-025 While rst_n is low, regardless of clk, the block SHALL hold:
  - j=0, k=0, cmd_done=0, busy=0;
  - FIFO empty, state IDLE, remaining=0.
REQ-026 cmd_ready SHALL be 0 while rst_n is low, and SHALL be 1 from the first cycle after deassertion.
REQ-027 Reset asserted mid-DRIVE SHALL drop the current command and all queued commands without any further j/k activity.

Structure
REQ-028 Package jk_pkg SHALL hold:
  - the op enum (HOLD/CLR/SET/TOG) and its encodings;
  - the FSM state typedef;
  - default DEPTH and CNT_W constants.
REQ-029 The FIFO SHALL be a sub-module jk_cmd_fifo (storage, pointers, full/empty, flush); the FSM and output registers SHALL stay in jk_cmd_sequencer.

Verification
REQ-030 SET with cnt=3 accepted at edge 1 (idle, empty) -> j=1,k=0 after edges 2,3,4; cmd_done high in the cycle after edge 4; j=k=0 after edge 5; busy low after edge 5.
REQ-031 TOG cnt=2 then CLR cnt=1 pushed back-to-back -> j/k=11,11,01 in consecutive cycles with no gap; two cmd_done pulses.
REQ-032 Push 5 commands with DEPTH=4 while a cnt=15 HOLD is driving -> cmd_ready low after 4 queued; the 5th is held until a pop, then accepted; all 5 execute in order.
REQ-033 cmd_cnt=0 SET -> exactly one drive cycle with j=1,k=0 and cmd_done in that cycle.
REQ-034 flush during cycle 2 of a SET cnt=8 with 3 queued, plus a same-cycle push -> next cycle j=k=0, busy=0, no cmd_done; the pushed command is never driven.
REQ-035 rst_n low mid-DRIVE (asynchronously, between edges) -> j,k,busy drop to 0 immediately; after release only commands pushed after release execute.

Source files
------------

// File: rtl/jk_pkg.sv
// Shared types and default sizing for the JK command sequencer.
// Op encodings map directly onto the downstream J/K drive pair.
package jk_pkg;

    localparam int JK_DEPTH_DEF = 4;
    localparam int JK_CNT_W_DEF = 4;

    typedef enum logic [1:0] {
        OP_HOLD = 2'b00,
        OP_CLR  = 2'b01,
        OP_SET  = 2'b10,
        OP_TOG  = 2'b11
    } jk_op_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRIVE = 1'b1
    } jk_state_e;

    // Returns {j, k} for an op.
    function automatic logic [1:0] op_to_jk(input jk_op_e op);
        logic [1:0] jk;
        case (op)
            OP_CLR:  jk = 2'b01;
            OP_SET:  jk = 2'b10;
            OP_TOG:  jk = 2'b11;
            default: jk = 2'b00;
        endcase
        return jk;
    endfunction

endpackage

// File: rtl/jk_cmd_fifo.sv
// Command FIFO: registered storage, extra-bit pointers, flush clears all entries.
// Push is dropped when full or flushing; pop is ignored when empty or flushing.
module jk_cmd_fifo
    import jk_pkg::*;
#(
    parameter int DEPTH = JK_DEPTH_DEF,
    parameter int W     = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush_i,
    input  logic         push_i,
    input  logic [W-1:0] wdata_i,
    input  logic         pop_i,
    output logic [W-1:0] rdata_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic [W-1:0] mem_q [DEPTH];
    logic         do_push, do_pop;

    // Same index with differing wrap bit means the writer lapped the reader.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/jk_cmd_sequencer.sv
// Queues {op, cnt} commands and drives registered J/K for cnt cycles each, back to back.
// First drive cycle follows the edge after acceptance; cmd_ready drops when full or flushing.
module jk_cmd_sequencer
    import jk_pkg::*;
#(
    parameter int DEPTH = JK_DEPTH_DEF,
    parameter int CNT_W = JK_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_cnt,
    output logic             cmd_ready,
    input  logic             flush,
    output logic             j,
    output logic             k,
    output logic             busy,
    output logic             cmd_done
);

    localparam int               FW      = 2 + CNT_W;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    jk_state_e        state_q, state_d;
    jk_op_e           op_q, op_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             j_q, j_d, k_q, k_d;

    logic             fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [FW-1:0]    fifo_rdata;
    jk_op_e           head_op;
    logic [CNT_W-1:0] head_cnt;
    logic             last_cycle;

    // rst_n gates ready so nothing is offered as accepted while held in reset.
    assign cmd_ready  = rst_n && !fifo_full && !flush;
    assign fifo_push  = cmd_valid && cmd_ready;
    assign head_op    = jk_op_e'(fifo_rdata[FW-1 -: 2]);
    assign head_cnt   = fifo_rdata[CNT_W-1:0];
    assign last_cycle = (state_q == ST_DRIVE) && (rem_q == CNT_ONE);

    jk_cmd_fifo #(
        .DEPTH (DEPTH),
        .W     (FW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (flush),
        .push_i  (fifo_push),
        .wdata_i ({cmd_op, cmd_cnt}),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        rem_d      = rem_q;
        fifo_pop   = 1'b0;
        {j_d, k_d} = 2'b00;
        if (flush) begin
            state_d = ST_IDLE;
            rem_d   = '0;
        end else if ((state_q == ST_IDLE) || last_cycle) begin
            // Loading on the last drive cycle keeps consecutive commands gap-free.
            if (!fifo_empty) begin
                fifo_pop   = 1'b1;
                state_d    = ST_DRIVE;
                op_d       = head_op;
                rem_d      = (head_cnt == '0) ? CNT_ONE : head_cnt;
                {j_d, k_d} = op_to_jk(head_op);
            end else begin
                state_d = ST_IDLE;
                rem_d   = '0;
            end
        end else begin
            rem_d      = rem_q - CNT_ONE;
            {j_d, k_d} = op_to_jk(op_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= OP_HOLD;
            rem_q   <= '0;
            j_q     <= 1'b0;
            k_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rem_q   <= rem_d;
            j_q     <= j_d;
            k_q     <= k_d;
        end
    end

    assign j        = j_q;
    assign k        = k_q;
    assign busy     = (state_q == ST_DRIVE) || !fifo_empty;
    assign cmd_done = last_cycle && !flush;

endmodule
